// File: rtl/mul_pkg.sv
`default_nettype none
// -----------------------------------------------------------------------------
// mul_pkg: shared state encoding and datapath widths for mul_arbiter. Rev 1.0
// -----------------------------------------------------------------------------
package mul_pkg;

    localparam int OP_W   = 32;
    localparam int PROD_W = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// -----------------------------------------------------------------------------
// rr_arbiter: combinational round-robin pick starting the search at ptr_i. Rev 1.0
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic               any_o
);

    int               k_int;
    logic [IDX_W-1:0] k_idx;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        k_int   = 0;
        k_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            k_int = (int'(ptr_i) + i) % NUM_REQ;
            k_idx = IDX_W'(k_int);
            if (!any_o && req_i[k_idx]) begin
                any_o          = 1'b1;
                grant_o[k_idx] = 1'b1;
                idx_o          = k_idx;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mul_arbiter.sv
`default_nettype none
// -----------------------------------------------------------------------------
// mul_arbiter: round-robin front end sharing one multi-cycle multiplier. Rev 1.0
// Optional: MUL_ARB_ZERO_BYPASS_EN returns zero-operand products without the engine.
// -----------------------------------------------------------------------------
module mul_arbiter
    import mul_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int MUL_LATENCY = 33
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [OP_W*NUM_REQ-1:0]    req_a,
    input  logic [OP_W*NUM_REQ-1:0]    req_b,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0] rsp_id,
    output logic [PROD_W-1:0]          rsp_product,
    output logic                       mul_load,
    output logic [OP_W-1:0]            mul_a,
    output logic [OP_W-1:0]            mul_b,
    input  logic [PROD_W-1:0]          mul_product,
    output logic                       busy
);

    localparam int                IDX_W    = $clog2(NUM_REQ);
    localparam int                CNT_W    = $clog2(MUL_LATENCY + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(MUL_LATENCY - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(NUM_REQ - 1);

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    ptr_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                rsp_valid_q;
    logic [IDX_W-1:0]    rsp_id_q;
    logic [PROD_W-1:0]   rsp_product_q;
    logic                mul_load_q;
    logic [OP_W-1:0]     mul_a_q, mul_b_q;
    logic                busy_q;

    logic [NUM_REQ-1:0]  gnt_vec;
    logic [IDX_W-1:0]    gnt_idx;
    logic                gnt_any;
    logic [OP_W-1:0]     sel_a, sel_b;
    logic                zero_op;
    logic                cnt_done;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .req_i   (req_valid),
        .ptr_i   (ptr_q),
        .grant_o (gnt_vec),
        .idx_o   (gnt_idx),
        .any_o   (gnt_any)
    );

    assign sel_a    = req_a[gnt_idx*OP_W +: OP_W];
    assign sel_b    = req_b[gnt_idx*OP_W +: OP_W];
    assign cnt_done = (cnt_q == CNT_LAST);

`ifdef MUL_ARB_ZERO_BYPASS_EN
    assign zero_op = (sel_a == '0) || (sel_b == '0);
`else
    assign zero_op = 1'b0;
`endif

    // Gated by rst so no accept strobe leaks out while reset is being applied.
    assign req_ready = (state_q == IDLE && rst) ? gnt_vec : '0;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (gnt_any) state_d = zero_op ? DONE : LOAD;
            LOAD: state_d = RUN;
            RUN:  if (cnt_done) state_d = DONE;
            DONE: if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= IDLE;
            ptr_q         <= '0;
            cnt_q         <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_id_q      <= '0;
            rsp_product_q <= '0;
            mul_load_q    <= 1'b0;
            mul_a_q       <= '0;
            mul_b_q       <= '0;
            busy_q        <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d != IDLE);
            case (state_q)
                IDLE: begin
                    if (gnt_any) begin
                        ptr_q    <= (gnt_idx == IDX_LAST) ? '0 : gnt_idx + 1'b1;
                        rsp_id_q <= gnt_idx;
                        mul_a_q  <= sel_a;
                        mul_b_q  <= sel_b;
                        if (zero_op) begin
                            rsp_product_q <= '0;
                            rsp_valid_q   <= 1'b1;
                        end else begin
                            mul_load_q <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    mul_load_q <= 1'b0;
                    cnt_q      <= '0;
                end
                RUN: begin
                    if (cnt_done) begin
                        rsp_product_q <= mul_product;
                        rsp_valid_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    if (rsp_ready) rsp_valid_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign rsp_valid   = rsp_valid_q;
    assign rsp_id      = rsp_id_q;
    assign rsp_product = rsp_product_q;
    assign mul_load    = mul_load_q;
    assign mul_a       = mul_a_q;
    assign mul_b       = mul_b_q;
    assign busy        = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_mul_arbiter.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tb_mul_arbiter: table, hand-written and random checks of mul_arbiter. Rev 1.0
// -----------------------------------------------------------------------------
module tb_mul_arbiter;

    localparam int N = 4;
    localparam int L = 33;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [N-1:0]  req_valid;
    logic [N-1:0]  req_ready;
    logic [32*N-1:0] req_a, req_b;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [1:0]    rsp_id;
    logic [63:0]   rsp_product;
    logic          mul_load;
    logic [31:0]   mul_a, mul_b;
    logic [63:0]   mul_product;
    logic          busy;

    int n_checks = 0;
    int n_fail   = 0;
    int eng_cnt  = 255;
    int mdl_ptr  = 0;
    int opa[N];
    int opb[N];

    mul_arbiter #(.NUM_REQ(N), .MUL_LATENCY(L)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_product (rsp_product),
        .mul_load    (mul_load),
        .mul_a       (mul_a),
        .mul_b       (mul_b),
        .mul_product (mul_product),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Engine stand-in: output is garbage until L cycles after the load pulse ends.
    always @(posedge clk) begin
        if (mul_load)          eng_cnt <= 0;
        else if (eng_cnt < 255) eng_cnt <= eng_cnt + 1;
    end
    assign mul_product = (eng_cnt >= L - 1) ?
                         (longint'($signed(mul_a)) * longint'($signed(mul_b))) :
                         64'hDEAD_BEEF_DEAD_BEEF;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pack();
        for (int k = 0; k < N; k++) begin
            req_a[32*k +: 32] = opa[k];
            req_b[32*k +: 32] = opb[k];
        end
    endtask

    function automatic int pick(input logic [N-1:0] mask);
        for (int i = 0; i < N; i++) begin
            if (mask[(mdl_ptr + i) % N]) return (mdl_ptr + i) % N;
        end
        return 0;
    endfunction

    task automatic apply_reset();
        rst       = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b0;
        step();
        step();
        rst     = 1'b1;
        mdl_ptr = 0;
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk({nm, "_ctl"}, {59'd0, rsp_valid, rsp_id, mul_load, busy}, 64'd0);
        chk({nm, "_ready"}, {60'd0, req_ready}, 64'd0);
        chk({nm, "_product"}, rsp_product, 64'd0);
        chk({nm, "_operands"}, {mul_a, mul_b}, 64'd0);
    endtask

    // One complete transaction, beginning in an IDLE cycle.
    task automatic run_op(input logic [N-1:0] mask, input int exp_id,
                          input logic [63:0] exp_p, input int hold);
        int k, loads, bad, exp_lat, exp_loads, seen;
        logic [63:0] ab_seen;
        exp_lat   = L + 2;
        exp_loads = 1;
`ifdef MUL_ARB_ZERO_BYPASS_EN
        if (opa[exp_id] == 0 || opb[exp_id] == 0) begin
            exp_lat   = 1;
            exp_loads = 0;
        end
`endif
        pack();
        req_valid = mask;
        rsp_ready = 1'b0;
        #1;
        chk("grant", {60'd0, req_ready}, 64'd1 << exp_id);
        loads   = 0;
        bad     = 0;
        seen    = 0;
        ab_seen = '0;
        for (k = 1; k <= 100; k++) begin
            step();
            if (k == 1) ab_seen = {mul_a, mul_b};
            if (mul_load) begin
                loads++;
                if (k != 1) bad++;
            end
            if (req_ready != '0) bad++;
            if (rsp_valid) begin
                seen = 1;
                break;
            end
        end
        chk("rsp_latency", 64'(k), 64'(exp_lat));
        if (seen == 0) begin
            apply_reset();
            return;
        end
        chk("load_pulses", 64'(loads), 64'(exp_loads));
        chk("busy_quiet", 64'(bad), 64'd0);
        chk("operands", ab_seen, {opa[exp_id], opb[exp_id]});
        chk("rsp_id", 64'(rsp_id), 64'(exp_id));
        chk("rsp_product", rsp_product, exp_p);
        chk("busy_done", 64'(busy), 64'd1);
        if (hold > 0) begin
            bad = 0;
            for (int h = 0; h < hold; h++) begin
                step();
                if (!rsp_valid || rsp_id != 2'(exp_id) || rsp_product != exp_p ||
                    req_ready != '0) bad++;
            end
            chk("backpressure_stable", 64'(bad), 64'd0);
        end
        rsp_ready = 1'b1;
        step();
        chk("rsp_drop", {62'd0, rsp_valid, busy}, 64'd0);
        rsp_ready = 1'b0;
        mdl_ptr   = (exp_id + 1) % N;
    endtask

    typedef struct {
        logic [N-1:0] mask;
        int           id;
        int           a;
        int           b;
        logic [63:0]  p;
        int           hold;
    } vec_t;

    vec_t tbl[7];

    initial begin
        int cnt;
        logic [N-1:0] m;
        int id;
        req_valid = '0;
        rsp_ready = 1'b0;
        req_a     = '0;
        req_b     = '0;
        for (int k = 0; k < N; k++) begin
            opa[k] = 0;
            opb[k] = 0;
        end

        tbl[0] = '{4'b0001, 0, 7,            -3,           -64'sd21,               0};
        tbl[1] = '{4'b0011, 1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 0};
        tbl[2] = '{4'b0011, 0, -1,           1,            64'hFFFF_FFFF_FFFF_FFFF, 2};
        tbl[3] = '{4'b1000, 3, 0,            5,            64'd0,                  10};
        tbl[4] = '{4'b0110, 1, 12345,        -678,         -64'sd8369910,          0};
        tbl[5] = '{4'b0010, 1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001, 1};
        tbl[6] = '{4'b1111, 2, -100000,      -3,           64'd300000,             0};

        repeat (3) step();
        chk_reset_outputs("reset");
        req_valid = '1;
        #1;
        chk("reset_no_ready", {60'd0, req_ready}, 64'd0);
        req_valid = '0;
        rst = 1'b1;
        step();

        for (int r = 0; r < 7; r++) begin
            for (int k = 0; k < N; k++) begin
                opa[k] = 100 + k;
                opb[k] = -(k + 1);
            end
            opa[tbl[r].id] = tbl[r].a;
            opb[tbl[r].id] = tbl[r].b;
            run_op(tbl[r].mask, tbl[r].id, tbl[r].p, tbl[r].hold);
        end
        req_valid = '0;

        apply_reset();
        for (int k = 0; k < N; k++) begin
            opa[k] = k + 2;
            opb[k] = k - 5;
        end
        for (int i = 0; i < 8; i++)
            run_op(4'b1111, i % N, 64'(longint'(opa[i % N]) * longint'(opb[i % N])), 0);

        // Abort mid-RUN: request is accepted, reset lands while the counter reads 15.
        opa[2] = 9;
        opb[2] = 9;
        pack();
        req_valid = 4'b0100;
        #1;
        chk("abort_grant", {60'd0, req_ready}, 64'b0100);
        repeat (17) step();
        rst = 1'b0;
        step();
        rst       = 1'b1;
        req_valid = '0;
        #1;
        chk_reset_outputs("abort");
        mdl_ptr = 0;
        cnt = 0;
        repeat (45) begin
            step();
            if (rsp_valid || busy || mul_load) cnt++;
        end
        chk("abort_silent", 64'(cnt), 64'd0);
        opa[0] = -5;
        opb[0] = 11;
        run_op(4'b1111, 0, -64'sd55, 0);

        repeat (16) begin
            m = 4'($urandom_range(1, 15));
            for (int k = 0; k < N; k++) begin
                opa[k] = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom);
                opb[k] = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom);
            end
            id = pick(m);
            run_op(m, id, 64'(longint'(opa[id]) * longint'(opb[id])),
                   int'($urandom_range(0, 3)));
        end
        req_valid = '0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/mul_arbiter.md
MUL_ARBITER -- requirements
Module: mul_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters sharing the multiplier (2..8).
REQ-002 Parameter MUL_LATENCY, default 33, number of cycles from mul_load deassertion until mul_product is stable.
REQ-003 clk  input  1  single clock; all logic is rising-edge triggered.
REQ-004 rst  input  1  synchronous, active-low reset.
REQ-005 req_valid  input  NUM_REQ  per-requester operation request.
REQ-006 req_ready  output  NUM_REQ  per-requester accept strobe; at most one bit is set.
REQ-007 req_a / req_b  input  32*NUM_REQ each  packed signed operands; requester k uses slice [32k+31:32k].
REQ-008 rsp_valid  output  1  result available.
REQ-009 rsp_ready  input  1  result consumer ready.
REQ-010 rsp_id  output  clog2(NUM_REQ)  index of the requester owning the result.
REQ-011 rsp_product  output  64  signed product.
REQ-012 mul_load  output  1  active-high load pulse to the shared Booth engine.
REQ-013 mul_a / mul_b  output  32 each  engine operands, held stable from load until capture.
REQ-014 mul_product  input  64  engine result.
REQ-015 busy  output  1  high in every state except IDLE.

Function
REQ-016 FSM states are IDLE, LOAD, RUN, and DONE.
REQ-017 IDLE: if any req_valid is set, grant one requester, assert its req_ready for that cycle only, latch its operands into mul_a/mul_b and its index, then go to LOAD.
REQ-018 Arbitration is round-robin: search starts at (last granted index + 1) mod NUM_REQ; after reset, search starts at index 0.
REQ-019 LOAD: mul_load=1 for exactly one cycle, cycle counter cleared, then go to RUN.
REQ-020 RUN: the counter increments each cycle; when counter==MUL_LATENCY-1, capture mul_product into rsp_product and go to DONE.
REQ-021 DONE: rsp_valid=1, with rsp_id and rsp_product held stable until rsp_valid&&rsp_ready, then return to IDLE.
REQ-022 Latency: an accept in cycle T gives mul_load in T+1 and rsp_valid first in T+2+MUL_LATENCY; back-to-back throughput is one op per MUL_LATENCY+3 cycles.
REQ-023 req_ready is 0 outside IDLE; req_valid changes in non-IDLE states have no effect.
REQ-024 A requester dropping req_valid before grant is simply not selected; there is no error.
REQ-025 rsp_ready held high in DONE gives a single-cycle rsp_valid; the next grant may occur in the following IDLE cycle.
REQ-026 The counter is wide enough for MUL_LATENCY, does not wrap in RUN, and stops at capture.
REQ-027 All outputs are registered, except req_ready, which is decoded from state and grant.

Reset
REQ-028 On rst=0 at a rising edge, the FSM goes to IDLE regardless of current state, including mid-RUN; any in-flight result is discarded and no rsp_valid is issued for it.
REQ-029 Reset values: req_ready=0, rsp_valid=0, rsp_id=0, rsp_product=0, mul_load=0, mul_a=0, mul_b=0, busy=0, round-robin pointer=0, counter=0.

Configuration
REQ-030 Macro MUL_ARB_ZERO_BYPASS_EN: when defined, a granted op with req_a==0 or req_b==0 skips LOAD/RUN, goes directly to DONE with rsp_product=0, and gives rsp_valid in T+1.
REQ-031 Without MUL_ARB_ZERO_BYPASS_EN, every op, including zero operands, takes the full LOAD/RUN path and latency.

Structure
REQ-032 Shared package mul_pkg holds: the state enum (IDLE, LOAD, RUN, DONE), the operand width constant 32, and the product width constant 64.
REQ-033 The round-robin grant logic is one sub-module, rr_arbiter (inputs req vector and pointer; output one-hot grant and index); the multiplier engine itself stays outside this block.

Verification
REQ-034 Single request: req0 gives a=7, b=-3 -> req_ready[0] pulses once; mul_load one cycle later; rsp_valid at T+35 with rsp_id=0 and rsp_product=-21.
REQ-035 Fairness: all four req_valid held high over 8 ops -> grant order is 0,1,2,3,0,1,2,3.
REQ-036 Backpressure: rsp_ready low for 10 cycles in DONE -> rsp_valid, rsp_id, and rsp_product stay stable, and req_ready stays 0.
REQ-037 Reset mid-RUN: assert rst=0 at counter=15 -> next cycle is IDLE with all outputs at reset values and no rsp_valid; a new request then starts at index 0.
REQ-038 Extremes: a=0x80000000, b=0x80000000 -> rsp_product=0x4000000000000000; a=-1, b=1 -> rsp_product=-1.
REQ-039 Zero bypass, with MUL_ARB_ZERO_BYPASS_EN: a=0, b=5 -> rsp_valid at T+1 with product 0 and no mul_load; without the macro, rsp_valid comes at T+35.
